// File: rtl/memory_delay_tank.sv
// ============================================================================
// Module      : memory_delay_tank
// Description : Serial delay-line store. Models one mercury tank as a
//               circulating loop of WORDS x WORD_BITS bit-times, with word
//               addressed write/clear/read gating, an ungated monitor tap,
//               position/sync outputs, and a self-clearing sweep after reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module memory_delay_tank #(
  parameter  int WORD_BITS = 36,
  parameter  int WORDS     = 16,
  localparam int BA        = $clog2(WORD_BITS),
  localparam int WA        = $clog2(WORDS)
) (
  input  logic          r2_clk,
  input  logic          r2_rst_n,
  input  logic          r2_adv,
  input  logic          r2_mib,
  input  logic          r2_sel_en,
  input  logic [WA-1:0] r2_sel_word,
  input  logic          r2_clr,
  input  logic          r2_in,
  input  logic          r2_out,
  output logic          r2_mob,
  output logic          r2_monitor,
  output logic [BA-1:0] r2_bit_idx,
  output logic [WA-1:0] r2_word_idx,
  output logic          r2_sync,
  output logic          r2_ready
);

  localparam int DEPTH = WORDS * WORD_BITS;
  localparam int PW    = $clog2(DEPTH);

  localparam logic [PW-1:0] c_LAST_PTR  = PW'(DEPTH - 1);
  localparam logic [BA-1:0] c_LAST_BIT  = BA'(WORD_BITS - 1);
  localparam logic [WA-1:0] c_LAST_WORD = WA'(WORDS - 1);

  typedef enum logic {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t        r_state;
  logic          r_mem [DEPTH];
  logic [PW-1:0] r_ptr;
  logic [BA-1:0] r_bit_idx;
  logic [WA-1:0] r_word_idx;
  logic          r_mob;
  logic          r_monitor;
  logic          r_sync;
  logic          r_ready;

  logic w_b;
  logic w_match;
  logic w_new;
  logic w_step;
  logic w_we;
  logic w_wdata;

  // Bit arriving at the tank end, gate decode and the value to recirculate
  always_comb begin
    w_b     = r_mem[r_ptr];
    w_match = !r2_sel_en || (r2_sel_word == r_word_idx);
    if (w_match && r2_clr) begin
      w_new = 1'b0;
    end else if (w_match && r2_in) begin
      w_new = r2_mib;
    end else begin
      w_new = w_b;
    end
    w_step  = (r_state == S_RUN) && r2_adv;
    // The clear sweep writes every clock regardless of the bit-time strobe
    w_we    = (r_state == S_INIT) || w_step;
    w_wdata = (r_state == S_RUN) ? w_new : 1'b0;
  end

  // Loop storage: contents survive reset and are wiped by the INIT sweep instead
  always_ff @(posedge r2_clk) begin
    if (w_we) begin
      r_mem[r_ptr] <= w_wdata;
    end
  end

  // Sweep/run state machine, loop position and registered outputs
  always_ff @(posedge r2_clk or negedge r2_rst_n) begin
    if (!r2_rst_n) begin
      r_state    <= S_INIT;
      r_ptr      <= '0;
      r_bit_idx  <= '0;
      r_word_idx <= '0;
      r_mob      <= 1'b0;
      r_monitor  <= 1'b0;
      r_sync     <= 1'b0;
      r_ready    <= 1'b0;
    end else begin
      // Pointer and indices move together so ptr == word*WORD_BITS + bit holds
      if (w_we) begin
        r_ptr <= (r_ptr == c_LAST_PTR) ? '0 : r_ptr + 1'b1;
        if (r_bit_idx == c_LAST_BIT) begin
          r_bit_idx  <= '0;
          r_word_idx <= (r_word_idx == c_LAST_WORD) ? '0 : r_word_idx + 1'b1;
        end else begin
          r_bit_idx <= r_bit_idx + 1'b1;
        end
      end

      case (r_state)
        S_INIT: begin
          r_mob     <= 1'b0;
          r_monitor <= 1'b0;
          r_sync    <= 1'b0;
          if (r_ptr == c_LAST_PTR) begin
            r_state <= S_RUN;
            r_ready <= 1'b1;
          end
        end
        S_RUN: begin
          if (r2_adv) begin
            r_monitor <= w_new;
            r_mob     <= (w_match && r2_out) ? w_b : 1'b0;
            r_sync    <= (r_word_idx == '0) && (r_bit_idx == '0);
          end else begin
            r_sync <= 1'b0;
          end
        end
        default: begin
          r_state <= S_INIT;
        end
      endcase
    end
  end

  assign r2_mob      = r_mob;
  assign r2_monitor  = r_monitor;
  assign r2_bit_idx  = r_bit_idx;
  assign r2_word_idx = r_word_idx;
  assign r2_sync     = r_sync;
  assign r2_ready    = r_ready;

endmodule

`default_nettype wire

// File: tb/tb_memory_delay_tank.sv
// ============================================================================
// Module      : tb_memory_delay_tank
// Description : Scoreboard bench for memory_delay_tank. A behavioural loop
//               model queues the expected outputs of every clock; each test
//               task drains and compares the queues for its own scenario.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_memory_delay_tank;

  localparam int WB    = 36;
  localparam int WN    = 16;
  localparam int DEPTH = WB * WN;
  localparam logic [35:0] c_PAT = 36'h5_A5A5_A5A5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main tank (36 x 16)
  logic       rst_n = 1'b1, adv = 1'b0, mib = 1'b0, sel_en = 1'b0;
  logic [3:0] sel_word = 4'd0;
  logic       clr = 1'b0, in_g = 1'b0, out_g = 1'b0;
  logic       mob, mon, sync, ready;
  logic [5:0] bidx;
  logic [3:0] widx;

  memory_delay_tank #(.WORD_BITS(WB), .WORDS(WN)) dut (
    .r2_clk(clk), .r2_rst_n(rst_n), .r2_adv(adv), .r2_mib(mib),
    .r2_sel_en(sel_en), .r2_sel_word(sel_word), .r2_clr(clr), .r2_in(in_g),
    .r2_out(out_g), .r2_mob(mob), .r2_monitor(mon), .r2_bit_idx(bidx),
    .r2_word_idx(widx), .r2_sync(sync), .r2_ready(ready)
  );

  // Small tank (4 x 5): non-power-of-two word count, so out-of-range selects exist
  logic       s_rst_n = 1'b1, s_adv = 1'b0, s_mib = 1'b0, s_sel_en = 1'b0;
  logic [2:0] s_sel_word = 3'd0;
  logic       s_clr = 1'b0, s_in = 1'b0, s_out = 1'b0;
  logic       s_mob, s_mon, s_sync, s_ready;
  logic [1:0] s_bidx;
  logic [2:0] s_widx;

  memory_delay_tank #(.WORD_BITS(4), .WORDS(5)) dut_small (
    .r2_clk(clk), .r2_rst_n(s_rst_n), .r2_adv(s_adv), .r2_mib(s_mib),
    .r2_sel_en(s_sel_en), .r2_sel_word(s_sel_word), .r2_clr(s_clr), .r2_in(s_in),
    .r2_out(s_out), .r2_mob(s_mob), .r2_monitor(s_mon), .r2_bit_idx(s_bidx),
    .r2_word_idx(s_widx), .r2_sync(s_sync), .r2_ready(s_ready)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Behavioural model of the loop
  logic        m_mem [DEPTH];
  int          m_word = 0, m_bit = 0;
  logic        m_mob = 1'b0, m_mon = 1'b0;
  logic [12:0] sb[$];
  logic [12:0] act_q[$];
  int          sync_q[$];
  logic [35:0] cap [WN];

  task automatic model_reset();
    for (int k = 0; k < DEPTH; k++) m_mem[k] = 1'b0;
    m_word = 0; m_bit = 0; m_mob = 1'b0; m_mon = 1'b0;
    sb.delete(); act_q.delete(); sync_q.delete();
  endtask

  // Drive one clock of inputs, predict the outputs, then sample the DUT
  task automatic step(input logic a, input logic se, input logic [3:0] sw,
                      input logic c, input logic i, input logic mb, input logic o);
    int   wb, bb;
    logic b, match, nv, ms;
    adv = a; sel_en = se; sel_word = sw; clr = c; in_g = i; mib = mb; out_g = o;
    wb = m_word; bb = m_bit; ms = 1'b0;
    if (a) begin
      b     = m_mem[wb * WB + bb];
      match = !se || (sw == 4'(wb));
      nv    = (match && c) ? 1'b0 : (match && i) ? mb : b;
      m_mem[wb * WB + bb] = nv;
      m_mob = (match && o) ? b : 1'b0;
      m_mon = nv;
      ms    = (wb == 0) && (bb == 0);
      m_bit = m_bit + 1;
      if (m_bit == WB) begin
        m_bit  = 0;
        m_word = (m_word == WN - 1) ? 0 : m_word + 1;
      end
    end
    sb.push_back({m_mob, m_mon, ms, 6'(m_bit), 4'(m_word)});
    @(posedge clk); #1;
    cyc++;
    act_q.push_back({mob, mon, sync, bidx, widx});
    if (a) cap[wb][bb] = mob;
    if (sync) sync_q.push_back(cyc);
  endtask

  // mode: 0 -> mib=0, 1 -> mib=1, 2 -> mib follows c_PAT LSB first
  task automatic rev(input int n, input int div, input logic se, input logic [3:0] sw,
                     input logic c, input logic i, input int mode, input logic o);
    logic [35:0] pat;
    logic        mb;
    pat = c_PAT;
    for (int k = 0; k < n; k++) begin
      mb = (mode == 0) ? 1'b0 : (mode == 1) ? 1'b1 : pat[m_bit];
      step((k % div) == 0, se, sw, c, i, mb, o);
    end
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (n < 2000) begin
      n++;
      @(posedge clk); #1;
      if (ready) break;
    end
  endtask

  task automatic test_reset();
    int n;
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if ({ready, mob, mon, sync, bidx, widx} !== 10'b0) begin
      failures++;
      $display("FAIL reset_outputs got=%b exp=0", {ready, mob, mon, sync, bidx, widx});
    end
    @(posedge clk); #1;
    // Gates are active throughout the sweep; they must be ignored
    sel_en = 1'b0; in_g = 1'b1; mib = 1'b1; adv = 1'b0;
    rst_n = 1'b1;
    wait_ready(n);
    checks++;
    if (n !== DEPTH) begin
      failures++;
      $display("FAIL ready_latency got=%0d exp=%0d", n, DEPTH);
    end
    model_reset();
  endtask

  task automatic test_idle_revolution();
    logic [12:0] e, got;
    for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    rev(DEPTH, 1, 1'b0, 4'd0, 1'b0, 1'b0, 0, 1'b1);
    while (sb.size() > 0) begin
      e = sb.pop_front(); got = act_q.pop_front(); checks++;
      if (got !== e) begin failures++; $display("FAIL idle_stream got=%h exp=%h", got, e); end
    end
  endtask

  task automatic test_write_replay();
    logic [12:0] e, got;
    rev(DEPTH, 1, 1'b1, 4'd3, 1'b0, 1'b1, 2, 1'b0);
    rev(DEPTH, 1, 1'b1, 4'd3, 1'b0, 1'b0, 0, 1'b1);
    while (sb.size() > 0) begin
      e = sb.pop_front(); got = act_q.pop_front(); checks++;
      if (got !== e) begin failures++; $display("FAIL replay_stream got=%h exp=%h", got, e); end
    end
    checks++;
    if (cap[3] !== c_PAT) begin
      failures++; $display("FAIL replay_word3 got=%h exp=%h", cap[3], c_PAT);
    end
    checks++;
    if (cap[2] !== 36'h0 || cap[4] !== 36'h0) begin
      failures++; $display("FAIL replay_neighbours got=%h/%h exp=0", cap[2], cap[4]);
    end
  endtask

  task automatic test_clear_priority();
    logic [12:0] e, got;
    rev(DEPTH, 1, 1'b1, 4'd7, 1'b0, 1'b1, 2, 1'b0);
    rev(DEPTH, 1, 1'b1, 4'd3, 1'b0, 1'b1, 1, 1'b0);
    rev(DEPTH, 1, 1'b1, 4'd3, 1'b1, 1'b1, 1, 1'b0);
    rev(DEPTH, 1, 1'b0, 4'd0, 1'b0, 1'b0, 0, 1'b1);
    while (sb.size() > 0) begin
      e = sb.pop_front(); got = act_q.pop_front(); checks++;
      if (got !== e) begin failures++; $display("FAIL clear_stream got=%h exp=%h", got, e); end
    end
    checks++;
    if (cap[3] !== 36'h0) begin
      failures++; $display("FAIL clear_word3 got=%h exp=0", cap[3]);
    end
    checks++;
    if (cap[7] !== c_PAT) begin
      failures++; $display("FAIL clear_word7_kept got=%h exp=%h", cap[7], c_PAT);
    end
  endtask

  task automatic test_adv_strobe();
    logic [12:0] e, got;
    sync_q.delete();
    rev(3 * DEPTH * 2, 3, 1'b0, 4'd0, 1'b0, 1'b0, 0, 1'b1);
    while (sb.size() > 0) begin
      e = sb.pop_front(); got = act_q.pop_front(); checks++;
      if (got !== e) begin failures++; $display("FAIL strobe_stream got=%h exp=%h", got, e); end
    end
    checks++;
    if (sync_q.size() != 2) begin
      failures++; $display("FAIL strobe_sync_count got=%0d exp=2", sync_q.size());
    end else begin
      checks++;
      if (sync_q[1] - sync_q[0] != 3 * DEPTH) begin
        failures++; $display("FAIL strobe_sync_period got=%0d exp=%0d", sync_q[1] - sync_q[0], 3 * DEPTH);
      end
    end
    checks++;
    if (cap[7] !== c_PAT) begin
      failures++; $display("FAIL strobe_word7 got=%h exp=%h", cap[7], c_PAT);
    end
  endtask

  task automatic test_mirror();
    logic [12:0] e, got;
    rev(DEPTH, 1, 1'b0, 4'd0, 1'b0, 1'b0, 0, 1'b1);
    while (sb.size() > 0) begin
      e = sb.pop_front(); got = act_q.pop_front(); checks++;
      if (got !== e) begin failures++; $display("FAIL mirror_stream got=%h exp=%h", got, e); end
    end
  endtask

  task automatic test_reset_mid_write();
    logic [12:0] e, got;
    int n;
    for (int k = 0; k < DEPTH && !(m_word == 5 && m_bit == 10); k++)
      step(1'b1, 1'b1, 4'd5, 1'b0, 1'b1, 1'b1, 1'b0);
    while (sb.size() > 0) begin
      e = sb.pop_front(); got = act_q.pop_front(); checks++;
      if (got !== e) begin failures++; $display("FAIL midwrite_stream got=%h exp=%h", got, e); end
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({ready, mob, mon, sync, bidx, widx} !== 10'b0) begin
      failures++;
      $display("FAIL midwrite_reset_outputs got=%b exp=0", {ready, mob, mon, sync, bidx, widx});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    wait_ready(n);
    checks++;
    if (n !== DEPTH) begin
      failures++; $display("FAIL midwrite_ready_latency got=%0d exp=%0d", n, DEPTH);
    end
    model_reset();
    rev(DEPTH, 1, 1'b0, 4'd0, 1'b0, 1'b0, 0, 1'b1);
    while (sb.size() > 0) begin
      e = sb.pop_front(); got = act_q.pop_front(); checks++;
      if (got !== e) begin failures++; $display("FAIL post_reset_stream got=%h exp=%h", got, e); end
    end
    checks++;
    if (cap[5] !== 36'h0 || cap[7] !== 36'h0) begin
      failures++; $display("FAIL post_reset_words got=%h/%h exp=0", cap[5], cap[7]);
    end
  endtask

  task automatic test_out_of_range_word();
    int n;
    s_rst_n = 1'b0;
    @(posedge clk); #1;
    s_rst_n = 1'b1;
    n = 0;
    while (n < 200) begin
      n++;
      @(posedge clk); #1;
      if (s_ready) break;
    end
    checks++;
    if (n !== 20) begin failures++; $display("FAIL small_ready_latency got=%0d exp=20", n); end
    // Select word 6 of a 5-word tank: no write may land anywhere
    s_adv = 1'b1; s_sel_en = 1'b1; s_sel_word = 3'd6; s_in = 1'b1; s_mib = 1'b1;
    repeat (20) begin @(posedge clk); #1; end
    checks++;
    if (s_widx !== 3'd0 || s_bidx !== 2'd0) begin
      failures++; $display("FAIL small_wrap got=%0d/%0d exp=0/0", s_widx, s_bidx);
    end
    s_sel_en = 1'b0; s_in = 1'b0; s_out = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      checks++;
      if (s_mob !== 1'b0 || s_mon !== 1'b0) begin
        failures++; $display("FAIL small_unchanged got=%b%b exp=00 step=%0d", s_mob, s_mon, k);
      end
    end
    s_out = 1'b0; s_in = 1'b1;
    repeat (20) begin @(posedge clk); #1; end
    s_in = 1'b0; s_out = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      checks++;
      if (s_mob !== 1'b1 || s_mon !== 1'b1) begin
        failures++; $display("FAIL small_all_ones got=%b%b exp=11 step=%0d", s_mob, s_mon, k);
      end
    end
    s_adv = 1'b0;
  endtask

  initial begin
    test_reset();
    test_idle_revolution();
    test_write_replay();
    test_clear_priority();
    test_adv_strobe();
    test_mirror();
    test_reset_mid_write();
    test_out_of_range_word();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
